// File: rtl/mem_ctrl_pkg.sv
// Shared widths, state encoding and access-length codes for the byte-serial
// memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [2:0] LEN_BYTE = 3'd1;
  localparam logic [2:0] LEN_HALF = 3'd2;
  localparam logic [2:0] LEN_WORD = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_SAVE  = 2'd2
  } op_e;

  // Anything other than 1 or 2 bytes is treated as a full word.
  function automatic logic [2:0] len_bytes(input logic [2:0] code);
    case (code)
      LEN_BYTE: return LEN_BYTE;
      LEN_HALF: return LEN_HALF;
      default:  return LEN_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetch port, MEM-stage load/store port and byte-wide RAM port of mem_ctrl.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  // Requests (if_req, load, save) are levels held by the requester until the
  // matching one-cycle done pulse; the controller samples them only when idle.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_data;

  logic              load;
  logic              save;
  logic [ADDR_W-1:0] sl_reg_address;
  logic [DATA_W-1:0] sl_data;
  logic [2:0]        sl_data_length;
  logic              sl_data_signed;
  logic              mem_ctrl_done;
  logic [DATA_W-1:0] mem_ctrl_data;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport master (
    output if_req, if_addr, load, save, sl_reg_address, sl_data,
           sl_data_length, sl_data_signed, ram_din,
    input  if_done, if_data, mem_ctrl_done, mem_ctrl_data,
           ram_addr, ram_wr, ram_dout
  );

  modport slave (
    input  if_req, if_addr, load, save, sl_reg_address, sl_data,
           sl_data_length, sl_data_signed, ram_din,
    output if_done, if_data, mem_ctrl_done, mem_ctrl_data,
           ram_addr, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_ctrl_load_extend.sv
// Sign/zero extension of an assembled little-endian load word.
module load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [2:0]        len_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] word_o
);

  always_comb begin
    word_o = word_i;
    if (len_i == LEN_BYTE) begin
      word_o = {{24{signed_i & word_i[7]}}, word_i[7:0]};
    end else if (len_i == LEN_HALF) begin
      word_o = {{16{signed_i & word_i[15]}}, word_i[15:0]};
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests onto
// a single 8-bit synchronous RAM port.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus,
  output state_e     dbg_state
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              if_done_q, if_done_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic              mem_done_q, mem_done_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DATA_W-1:0] ext_word;
  logic [1:0]        rd_byte;
  logic [1:0]        wr_byte;

  load_extend u_load_extend (
    .word_i   (rdata_q),
    .len_i    (len_q),
    .signed_i (sgn_q),
    .word_o   (ext_word)
  );

  // cnt_q counts edges since the request was sampled; read data lags the
  // presented address by one cycle, so edge k captures byte k-2.
  assign rd_byte = cnt_q[1:0] - 2'd2;
  assign wr_byte = cnt_q[1:0];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    sgn_d      = sgn_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ram_wr_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_dout_d = ram_dout_q;
    if_done_d  = 1'b0;
    if_data_d  = if_data_q;
    mem_done_d = 1'b0;
    mem_data_d = mem_data_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 3'd1;
        if (bus.load) begin
          state_d    = ST_MEM_RD;
          op_d       = OP_LOAD;
          base_d     = bus.sl_reg_address;
          len_d      = len_bytes(bus.sl_data_length);
          sgn_d      = bus.sl_data_signed;
          rdata_d    = '0;
          ram_addr_d = bus.sl_reg_address;
        end else if (bus.save) begin
          state_d    = ST_MEM_WR;
          op_d       = OP_SAVE;
          base_d     = bus.sl_reg_address;
          len_d      = len_bytes(bus.sl_data_length);
          wdata_d    = bus.sl_data;
          ram_wr_d   = 1'b1;
          ram_addr_d = bus.sl_reg_address;
          ram_dout_d = bus.sl_data[7:0];
        end else if (bus.if_req) begin
          state_d    = ST_IF_RD;
          op_d       = OP_FETCH;
          base_d     = bus.if_addr;
          len_d      = LEN_WORD;
          sgn_d      = 1'b0;
          rdata_d    = '0;
          ram_addr_d = bus.if_addr;
        end
      end
      ST_IF_RD, ST_MEM_RD: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q < len_q) ram_addr_d = base_q + {29'd0, cnt_q};
        if (cnt_q >= 3'd2) rdata_d[{rd_byte, 3'b000} +: 8] = bus.ram_din;
        if (cnt_q == len_q + 3'd1) state_d = ST_DONE;
      end
      ST_MEM_WR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q < len_q) begin
          ram_wr_d   = 1'b1;
          ram_addr_d = base_q + {29'd0, cnt_q};
          ram_dout_d = wdata_q[{wr_byte, 3'b000} +: 8];
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
        case (op_q)
          OP_FETCH: begin
            // A fetch whose request vanished was flushed upstream.
            if (bus.if_req) begin
              if_done_d = 1'b1;
              if_data_d = rdata_q;
            end
          end
          OP_LOAD: begin
            mem_done_d = 1'b1;
            mem_data_d = ext_word;
          end
          default: mem_done_d = 1'b1;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_FETCH;
      cnt_q      <= '0;
      len_q      <= '0;
      sgn_q      <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_dout_q <= '0;
      if_done_q  <= 1'b0;
      if_data_q  <= '0;
      mem_done_q <= 1'b0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      sgn_q      <= sgn_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ram_wr_q   <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_dout_q <= ram_dout_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      mem_done_q <= mem_done_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign bus.ram_wr        = ram_wr_q;
  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_dout      = ram_dout_q;
  assign bus.if_done       = if_done_q;
  assign bus.if_data       = if_data_q;
  assign bus.mem_ctrl_done = mem_done_q;
  assign bus.mem_ctrl_data = mem_data_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed corner cases plus random
// fetch/load/store traffic against a byte-addressed reference memory.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int K_LOAD  = 0;
  localparam int K_SAVE  = 1;
  localparam int K_FETCH = 2;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     n_vec;
  int     n_err;

  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] last_if_exp;
  logic [31:0] last_mem_exp;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model: one-cycle read latency ----------------
  function automatic logic [7:0] dflt_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt_byte(a);
  endfunction

  always @(posedge clk) begin
    bus.ram_din <= ram_rd(bus.ram_addr);
    if (bus.ram_wr) ram[bus.ram_addr] = bus.ram_dout;
  end

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int len_of(input logic [2:0] code);
    return (code == 3'd1) ? 1 : (code == 3'd2) ? 2 : 4;
  endfunction

  // Expected read result: little-endian assembly, then arithmetic sign fix-up.
  function automatic logic [31:0] model_read(input logic [31:0] a, input int n, input bit sg);
    longint v;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_rd(a + 32'(i))) << (8 * i);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  task automatic clear_reqs();
    bus.if_req = 1'b0;
    bus.load   = 1'b0;
    bus.save   = 1'b0;
  endtask

  // ---------------- driver: one complete transaction ----------------
  task automatic do_xfer(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] lc, input bit sg);
    int          n;
    int          lat;
    logic [31:0] exp;
    logic        done;
    logic        other;
    n   = (kind == K_FETCH) ? 4 : len_of(lc);
    lat = (kind == K_SAVE) ? n + 1 : n + 2;
    exp = model_read(addr, n, (kind == K_LOAD) && sg);
    if (kind == K_SAVE)
      for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wd[8*i +: 8];
    @(negedge clk);
    bus.if_addr        = addr;
    bus.sl_reg_address = addr;
    bus.sl_data        = wd;
    bus.sl_data_length = lc;
    bus.sl_data_signed = sg;
    bus.if_req         = (kind == K_FETCH);
    bus.load           = (kind == K_LOAD);
    bus.save           = (kind == K_SAVE);
    for (int e = 0; e <= lat + 1; e++) begin
      @(posedge clk);
      #1;
      if (e < n) begin
        check_eq("ram_addr", bus.ram_addr, addr + 32'(e));
        check_eq("ram_wr", 32'(bus.ram_wr), 32'(kind == K_SAVE));
        if (kind == K_SAVE) check_eq("ram_dout", 32'(bus.ram_dout), 32'(wd[8*e +: 8]));
      end else begin
        check_eq("ram_wr_quiet", 32'(bus.ram_wr), 32'd0);
      end
      done  = (kind == K_FETCH) ? bus.if_done : bus.mem_ctrl_done;
      other = (kind == K_FETCH) ? bus.mem_ctrl_done : bus.if_done;
      check_eq("done_timing", 32'(done), 32'(e == lat));
      check_eq("other_done", 32'(other), 32'd0);
      if (e == lat) begin
        if (kind == K_FETCH) begin
          check_eq("if_data", bus.if_data, exp);
          check_eq("mem_data_hold", bus.mem_ctrl_data, last_mem_exp);
          last_if_exp = exp;
        end else begin
          if (kind == K_LOAD) last_mem_exp = exp;
          check_eq("mem_ctrl_data", bus.mem_ctrl_data, last_mem_exp);
          check_eq("if_data_hold", bus.if_data, last_if_exp);
        end
        clear_reqs();
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ram_wr"}, 32'(bus.ram_wr), 32'd0);
    check_eq({tag, "_ram_addr"}, bus.ram_addr, 32'd0);
    check_eq({tag, "_ram_dout"}, 32'(bus.ram_dout), 32'd0);
    check_eq({tag, "_if_done"}, 32'(bus.if_done), 32'd0);
    check_eq({tag, "_if_data"}, bus.if_data, 32'd0);
    check_eq({tag, "_mem_done"}, 32'(bus.mem_ctrl_done), 32'd0);
    check_eq({tag, "_mem_data"}, bus.mem_ctrl_data, 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int if_cnt;
    int mem_cnt;
    n_vec = 0;
    n_err = 0;
    last_if_exp  = '0;
    last_mem_exp = '0;
    rst = 1'b0;
    clear_reqs();
    bus.if_addr = '0;
    bus.sl_reg_address = '0;
    bus.sl_data = '0;
    bus.sl_data_length = 3'd4;
    bus.sl_data_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Word store, then byte loads signed/unsigned, then wrapping halfword load.
    do_xfer(K_SAVE, 32'h0000_0100, 32'hAABB_CCDD, 3'd4, 1'b0);
    preload(32'h0000_0200, 8'h80);
    do_xfer(K_LOAD, 32'h0000_0200, 32'h0, 3'd1, 1'b1);
    check_eq("lb_signed", last_mem_exp, 32'hFFFF_FF80);
    do_xfer(K_LOAD, 32'h0000_0200, 32'h0, 3'd1, 1'b0);
    check_eq("lb_unsigned", last_mem_exp, 32'h0000_0080);
    do_xfer(K_LOAD, 32'h0000_0100, 32'h0, 3'd4, 1'b0);
    check_eq("lw_after_sw", last_mem_exp, 32'hAABB_CCDD);
    preload(32'hFFFF_FFFF, 8'h34);
    preload(32'h0000_0000, 8'h12);
    do_xfer(K_LOAD, 32'hFFFF_FFFF, 32'h0, 3'd2, 1'b0);
    check_eq("lh_wrap", last_mem_exp, 32'h0000_1234);
    do_xfer(K_FETCH, 32'h0000_0100, 32'h0, 3'd4, 1'b0);

    // Simultaneous load and fetch: load first, then the held fetch.
    preload(32'h0000_0300, 8'hF0);
    preload(32'h0000_0301, 8'h8F);
    @(negedge clk);
    bus.sl_reg_address = 32'h0000_0300;
    bus.sl_data_length = 3'd2;
    bus.sl_data_signed = 1'b1;
    bus.if_addr = 32'h0000_0100;
    bus.load    = 1'b1;
    bus.if_req  = 1'b1;
    if_cnt  = 0;
    mem_cnt = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ctrl_done) begin
        mem_cnt++;
        check_eq("arb_load_first", 32'(if_cnt), 32'd0);
        check_eq("arb_load_data", bus.mem_ctrl_data, 32'hFFFF_8FF0);
        bus.load = 1'b0;
      end
      if (bus.if_done) begin
        if_cnt++;
        check_eq("arb_fetch_data", bus.if_data, 32'hAABB_CCDD);
        bus.if_req = 1'b0;
      end
    end
    check_eq("arb_mem_pulses", 32'(mem_cnt), 32'd1);
    check_eq("arb_if_pulses", 32'(if_cnt), 32'd1);
    last_mem_exp = 32'hFFFF_8FF0;
    last_if_exp  = 32'hAABB_CCDD;

    // Flushed fetch: request dropped mid-read, no pulse, data unchanged.
    @(negedge clk);
    bus.if_addr = 32'h0000_0200;
    bus.if_req  = 1'b1;
    if_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    bus.if_req = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      if (bus.if_done) if_cnt++;
    end
    check_eq("flush_no_done", 32'(if_cnt), 32'd0);
    check_eq("flush_idle", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("flush_if_data", bus.if_data, last_if_exp);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      int          k;
      logic [31:0] a;
      k = int'($urandom_range(2, 0));
      a = ($urandom_range(4, 0) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(3, 0))
                                      : 32'h0000_0400 + 32'($urandom_range(63, 0));
      do_xfer(k, a, $urandom(), 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
    end

    // Reset while the third byte of a word store is on the bus.
    @(negedge clk);
    bus.sl_reg_address = 32'h0000_0500;
    bus.sl_data        = 32'h1122_3344;
    bus.sl_data_length = 3'd4;
    bus.save           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_byte2_wr", 32'(bus.ram_wr), 32'd1);
    check_eq("abort_byte2_addr", bus.ram_addr, 32'h0000_0502);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    bus.save = 1'b0;
    rst = 1'b1;
    mem_cnt = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ctrl_done || bus.ram_wr) mem_cnt++;
    end
    check_eq("abort_no_done", 32'(mem_cnt), 32'd0);
    last_if_exp  = '0;
    last_mem_exp = '0;
    do_xfer(K_LOAD, 32'h0000_0100, 32'h0, 3'd2, 1'b1);
    check_eq("post_reset_lh", last_mem_exp, 32'hFFFF_CCDD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
